// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a show-ahead byte FIFO.
// One pop per frame; the byte is captured on the pop edge.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tx_enable_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_read_data_i,
    output logic       fifo_read_en_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (CLKS_PER_BIT < 2) begin : g_param_err
        $error("CLKS_PER_BIT must be 2 or more");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          pop;
    logic          bit_end;

    assign pop = (state_q == IDLE) && !fifo_empty_i
              && tx_enable_i && !reset_i;
    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = fifo_read_data_i;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign fifo_read_en_o = pop;
    assign tx_o           = tx_q;
    assign busy_o         = (state_q != IDLE);
    assign frame_done_o   = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (C=4, 2, 16) fed by FIFO models,
// checked every cycle against a frame-timing model plus literal frame checks.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst;
    logic [2:0] ten;
    logic [2:0] emp;
    logic [2:0] ren;
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] fd_w;
    logic [7:0] rdat [3];

    logic [7:0] mem [3][64];
    int         wr [3] = '{0, 0, 0};
    int         rd [3] = '{0, 0, 0};

    int         n = 0;
    bit         have [3] = '{0, 0, 0};
    int         pop_c [3] = '{0, 0, 0};
    logic [7:0] pop_b [3];
    bit         chk_on = 0;

    int errors = 0;
    int checks = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(4)) u_c4 (
        .clk_i(clk), .reset_i(rst), .tx_enable_i(ten[0]),
        .fifo_empty_i(emp[0]), .fifo_read_data_i(rdat[0]),
        .fifo_read_en_o(ren[0]), .tx_o(tx_w[0]),
        .busy_o(busy_w[0]), .frame_done_o(fd_w[0])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2)) u_c2 (
        .clk_i(clk), .reset_i(rst), .tx_enable_i(ten[1]),
        .fifo_empty_i(emp[1]), .fifo_read_data_i(rdat[1]),
        .fifo_read_en_o(ren[1]), .tx_o(tx_w[1]),
        .busy_o(busy_w[1]), .frame_done_o(fd_w[1])
    );

    fifo_uart_tx #(.CLKS_PER_BIT(16)) u_c16 (
        .clk_i(clk), .reset_i(rst), .tx_enable_i(ten[2]),
        .fifo_empty_i(emp[2]), .fifo_read_data_i(rdat[2]),
        .fifo_read_en_o(ren[2]), .tx_o(tx_w[2]),
        .busy_o(busy_w[2]), .frame_done_o(fd_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int i);
        case (i)
            0: return 4;
            1: return 2;
            default: return 16;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            emp[i]  = (wr[i] == rd[i]);
            rdat[i] = mem[i][rd[i] & 63];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, n);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr[i] & 63] = b;
        wr[i]++;
    endtask

    // Model: a frame is 10*C cycles long from the pop edge; FIFO pops on DUT strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                have[i] <= 1'b0;
            end else if (!(have[i] && (n - pop_c[i]) < 10 * cpb(i))
                         && !emp[i] && ten[i]) begin
                have[i]  <= 1'b1;
                pop_c[i] <= n + 1;
                pop_b[i] <= rdat[i];
            end
            if (ren[i]) rd[i] <= rd[i] + 1;
        end
        n <= n + 1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                int   c;
                int   k;
                logic be;
                logic te;
                logic fe;
                logic re;
                c  = cpb(i);
                k  = n - pop_c[i];
                be = have[i] && (k < 10 * c);
                if (!be)             te = 1'b1;
                else if (k < c)      te = 1'b0;
                else if (k >= 9 * c) te = 1'b1;
                else                 te = pop_b[i][k / c - 1];
                fe = have[i] && (k == 10 * c);
                re = !be && !emp[i] && ten[i] && !rst;
                chk($sformatf("model%0d_tx", i), int'(tx_w[i]), int'(te));
                chk($sformatf("model%0d_busy", i), int'(busy_w[i]), int'(be));
                chk($sformatf("model%0d_done", i), int'(fd_w[i]), int'(fe));
                chk($sformatf("model%0d_ren", i), int'(ren[i]), int'(re));
            end
        end
    end

    // Called at a negedge; waits for the pop and checks bit centres and timing.
    task automatic frame_check(input int i, input int c, input logic [7:0] b,
                               input string nm, input int drop_at,
                               input int abort_at, output int pe);
        int   t;
        int   bad;
        logic e;
        t   = 0;
        bad = 0;
        while (!ren[i] && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!ren[i]) begin
            chk({nm, "_pop_timeout"}, 0, 1);
            pe = -1;
            return;
        end
        pe = n + 1;
        for (int k = 0; k <= 10 * c; k++) begin
            @(negedge clk);
            if (k == drop_at) ten[i] = 1'b0;
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk({nm, "_rst_tx"}, int'(tx_w[i]), 1);
                chk({nm, "_rst_busy"}, int'(busy_w[i]), 0);
                chk({nm, "_rst_done"}, int'(fd_w[i]), 0);
                return;
            end
            if (k < 10 * c) begin
                if (k % c == c / 2) begin
                    if (k / c == 0)      e = 1'b0;
                    else if (k / c == 9) e = 1'b1;
                    else                 e = b[k / c - 1];
                    chk($sformatf("%s_bit%0d", nm, k / c),
                        int'(tx_w[i]), int'(e));
                end
                if (!busy_w[i] || fd_w[i] || ren[i]) bad++;
            end else begin
                chk({nm, "_done_at_10C"}, int'(fd_w[i]), 1);
                chk({nm, "_busy_at_10C"}, int'(busy_w[i]), 0);
            end
        end
        chk({nm, "_inframe_flags"}, bad, 0);
    endtask

    initial begin
        int pe1;
        int pe2;
        int pe3;
        int cnt;
        int r;
        rst = 1'b1;
        ten = 3'b000;
        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        chk("reset_tx", int'(tx_w[0]), 1);
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_done", int'(fd_w[0]), 0);
        chk("reset_ren", int'(ren[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single byte
        @(posedge clk);
        #1 push(0, 8'hA5);
        ten[0] = 1'b1;
        @(negedge clk);
        frame_check(0, 4, 8'hA5, "single", -1, -1, pe1);

        // back-to-back
        @(posedge clk);
        #1 push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        @(negedge clk);
        frame_check(0, 4, 8'h00, "b2b0", -1, -1, pe1);
        frame_check(0, 4, 8'hFF, "b2b1", -1, -1, pe2);
        frame_check(0, 4, 8'h3C, "b2b2", -1, -1, pe3);
        chk("b2b_gap1", pe2 - pe1, 41);
        chk("b2b_gap2", pe3 - pe2, 41);

        // empty
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ren[0] || !tx_w[0] || busy_w[0]) cnt++;
        end
        chk("empty_idle", cnt, 0);

        // disabled with data waiting
        @(posedge clk);
        #1 ten[0] = 1'b0;
        push(0, 8'h55);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ren[0]) cnt++;
        end
        chk("disabled_nopop", cnt, 0);
        @(posedge clk);
        #1 ten[0] = 1'b1;
        r = n;
        @(negedge clk);
        frame_check(0, 4, 8'h55, "enrise", -1, -1, pe1);
        chk("enrise_pop_edge", pe1, r + 1);

        // tx_enable dropped mid-frame
        @(posedge clk);
        #1 push(0, 8'h81);
        push(0, 8'h7E);
        @(negedge clk);
        frame_check(0, 4, 8'h81, "drop", 10, -1, pe1);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (ren[0]) cnt++;
        end
        chk("drop_nopop", cnt, 0);
        chk("drop_fifo_left", wr[0] - rd[0], 1);
        @(posedge clk);
        #1 ten[0] = 1'b1;
        @(negedge clk);
        frame_check(0, 4, 8'h7E, "resume", -1, -1, pe1);

        // reset mid-frame
        @(posedge clk);
        #1 push(0, 8'hC3);
        push(0, 8'h99);
        @(negedge clk);
        frame_check(0, 4, 8'hC3, "abort", -1, 17, pe1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        frame_check(0, 4, 8'h99, "after_rst", -1, -1, pe1);
        chk("after_rst_fifo_empty", wr[0] - rd[0], 0);

        // parameter sweep
        @(posedge clk);
        #1 push(1, 8'hA5);
        ten[1] = 1'b1;
        @(negedge clk);
        frame_check(1, 2, 8'hA5, "c2", -1, -1, pe1);
        @(posedge clk);
        #1 push(2, 8'hA5);
        ten[2] = 1'b1;
        @(negedge clk);
        frame_check(2, 16, 8'hA5, "c16", -1, -1, pe1);

        // random bytes through the C=4 instance with random gaps
        for (int j = 0; j < 6; j++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            @(posedge clk);
            #1 push(0, rb);
            @(negedge clk);
            frame_check(0, 4, rb, $sformatf("rnd%0d", j), -1, -1, pe1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-deep synchronous byte FIFO.
- Pops bytes through the FIFO's empty/read_en/read_data interface and serialises each one as a UART 8N1 frame on a single line.
- FIFO read data is show-ahead: read_data always reflects the head entry while empty is low. This block samples that data on the same edge that it pops the entry.
- Sits between the FIFO and the board TX pin.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Legal values are 2 or more; a lower value is a parameter error. The bit counter is sized to hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- tx_enable  input  1  permits new frames to start; it has no effect on a frame already in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_data  input  8  FIFO head entry; valid whenever fifo_empty is 0.
- fifo_read_en  output  1  FIFO pop strobe; combinational.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse, registered, marking the end of a frame.

Behaviour:
- Reset values: state=IDLE, tx=1, busy=0, frame_done=0, bit counter=0, bit index=0, shift register=0. fifo_read_en=0 while reset is high.
- States: IDLE, START, DATA, STOP.
- fifo_read_en = (state==IDLE) && !fifo_empty && tx_enable && !reset. It is never asserted in any other state, so at most one pop occurs per frame.
- IDLE transition: on an edge where fifo_read_en=1 (call it E0), the block loads shift<=fifo_read_data, sets tx<=0 and cnt<=0, and moves to START.
- START: tx held 0 for CLKS_PER_BIT cycles starting at E0. At E0+C (C=CLKS_PER_BIT): state<=DATA, tx<=shift[0], idx<=0.
- DATA: each bit is held for C cycles, LSB first. At the end of bit idx<7 the shift register shifts right and tx<=the next bit. At the end of bit 7 (E0+9C): state<=STOP, tx<=1.
- STOP: tx=1 for C cycles. At E0+10C: state<=IDLE, frame_done<=1 for exactly one cycle.
- Back-to-back frames: the IDLE cycle after STOP may assert fifo_read_en. In that case the next start bit begins at E0+10C+1. Effective stop length is therefore C+1 cycles, and the minimum frame period is 10C+1 cycles.
- The bit counter counts 0..C-1 and wraps to 0 at each bit boundary. idx wraps 7->0 only on entry to DATA.
- tx_enable deasserted mid-frame: the frame completes normally, and no further pop occurs until tx_enable returns high.
- fifo_empty rising mid-frame: ignored. Data was captured at E0, and a later FIFO write or read does not alter the frame.
- FIFO full: no effect on this block. The FIFO's own write-side gating handles it.
- Reset mid-frame: on the reset edge, tx<=1, state<=IDLE, frame_done<=0. The partial frame is abandoned and not retried; the popped byte is lost. No pop occurs on the reset edge.
- fifo_read_data is never sampled except on a pop edge.

Test Plan (CLKS_PER_BIT=4 unless stated):
- Single byte: FIFO holds 0xA5, tx_enable=1.
  - fifo_read_en is high for exactly 1 cycle.
  - tx pattern, one bit per 4 clocks: 0 (start), 1,0,1,0,0,1,0,1 (LSB first), 1 (stop).
  - frame_done pulses 40 cycles after the pop edge; busy is high for those 40 cycles.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C.
  - Three pops occur, spaced exactly 41 cycles apart.
  - The decoded line carries 0x00, 0xFF, 0x3C in order.
  - tx never glitches low between a stop bit and the next start bit except at the start bit itself.
- Empty and disabled:
  - With fifo_empty=1 for 100 cycles: no pop, tx=1, busy=0.
  - With FIFO holding 0x55 but tx_enable=0: no pop. The pop occurs on the first edge after tx_enable rises.
- tx_enable dropped mid-frame: tx_enable falls at cycle 10 of a 0x81 frame.
  - The frame completes all 40 cycles with correct bits.
  - No second pop occurs although the FIFO still holds 0x7E.
- Reset mid-frame: assert reset at cycle 17 of a 0xC3 frame.
  - tx=1 and busy=0 from the next edge, and frame_done stays 0.
  - After reset releases, the next FIFO byte 0x99 is sent as a complete frame.
- Parameter sweep: repeat the single-byte case with CLKS_PER_BIT=2 and 16.
  - Frame length is 20 and 160 cycles respectively.
  - Each bit holds exactly C cycles, checked by a monitor sampling at bit centres.
